beat_recorder: RTL and testbench
================================

Name: beat_recorder

Overview:
- Beat-synchronous melody recorder/player clocked by clk22, one beat per clk22 cycle.
- In RECORD it samples the currently held key index once per beat and writes it into an internal score RAM. It is the writer side of the beat-indexed score ROM read by the music sequencer.
- In PLAY it reads the stored score back beat by beat and emits a tone frequency in Hz.
- tone_out feeds the existing 50 MHz/tone divider path to note_gen. Keyboard scan-code decode to note index is done upstream.

Parameters:
- ADDR_W, 10, score RAM address width; DEPTH = 2**ADDR_W beats.
- LOOP, 1, PLAY behaviour at end of score: 1 = wrap to beat 0, 0 = return to IDLE.
- REST_TONE, 32'd20000, tone_out value for rest/silence; never 0.

Ports:
- clk22  input  1  beat clock.
- rst  input  1  reset, asynchronous, active-high.
- rec_start  input  1  level; its rising edge requests RECORD.
- play_start  input  1  level; its rising edge requests PLAY.
- stop  input  1  level; its rising edge requests IDLE.
- note_in  input  4  0 = rest, 1..8 = C4..C5; 9..15 are treated as rest.
- tone_out  output  32  current tone in Hz, registered.
- state_out  output  2  0 IDLE, 1 RECORD, 2 PLAY.
- beat_idx  output  ADDR_W  current write or read pointer.
- rec_len  output  ADDR_W+1  number of recorded beats, 0..DEPTH.
- full  output  1  last RECORD ended because the RAM filled.

Behaviour:
- Reset values: state IDLE, tone_out = REST_TONE, beat_idx 0, rec_len 0, full 0, edge-detect history regs 0. RAM contents are not cleared, but rec_len 0 makes them unreachable.
- Edge detect: each control input is registered once. A command is (in & ~in_q), evaluated on a clk22 edge. Levels already high at reset release do not fire.
- Command priority on the same edge: stop > rec_start > play_start.
- Note-to-tone LUT: 1:262, 2:294, 3:330, 4:349, 5:392, 6:440, 7:494, 8:523. 0 and 9..15 map to REST_TONE.
- IDLE:
  - tone_out = REST_TONE.
  - rec_start edge -> RECORD; beat_idx 0, rec_len 0, full 0.
  - play_start edge with rec_len > 0 -> PLAY; beat_idx 0.
  - play_start edge with rec_len == 0 is ignored.
- RECORD, each edge without stop:
  - mem[beat_idx] <= note_in (sanitised; 9..15 stored as 0).
  - tone_out <= LUT(note_in) as a monitor.
  - rec_len <= rec_len + 1.
  - If beat_idx == DEPTH-1: write, set full 1, go to IDLE, beat_idx 0. Otherwise beat_idx + 1.
  - First write occurs on the edge after the entry edge.
- RECORD, stop edge: no write; go to IDLE; beat_idx 0; rec_len holds; tone_out = REST_TONE.
- RECORD, rec_start edge: restart; beat_idx 0, rec_len 0, no write on that edge.
- RECORD, play_start edge: ignored.
- PLAY read path: synchronous read, 1-cycle RAM latency, then a registered LUT. tone_out for beat k appears 2 edges after beat_idx = k is presented. Total latency from the play_start edge to the first non-rest tone is 2 clk22 cycles.
- PLAY pointer: increments every edge. At beat_idx == rec_len-1:
  - LOOP=1: next is 0.
  - LOOP=0: go to IDLE after issuing the last read; tone_out shows the last note one more cycle, then REST_TONE.
- PLAY commands:
  - stop edge -> IDLE; tone_out = REST_TONE on the next edge.
  - rec_start edge -> RECORD; entry as from IDLE.
  - play_start edge -> restart at beat 0.
- rec_len == DEPTH is representable (ADDR_W+1 bits); wrap compare uses rec_len-1.
- rst asserted mid-RECORD or mid-PLAY: all registers return to reset values immediately and no RAM write occurs while rst is high.

Test Plan:
- Basic record: reset; rec_start pulse; note_in 1,3,5,0 on 4 consecutive edges; stop -> rec_len = 4, state_out 0, full 0.
- Playback with LOOP=1: play_start -> tone_out sequence 262, 330, 392, REST_TONE, 262, ... from the 2nd edge after the command; beat_idx wraps 3->0.
- End of score with LOOP=0: same recording -> after REST_TONE for beat 3, state_out = 0 and tone_out stays REST_TONE.
- Full RAM with ADDR_W=3: hold note_in = 6 for 10 edges after rec_start -> rec_len = 8, full = 1, auto IDLE after the 8th write; play gives 440 repeated.
- Edge cases:
  - play_start with rec_len 0 -> stays IDLE.
  - stop, rec_start and play_start rising on the same edge -> IDLE.
  - note_in = 12 recorded -> plays REST_TONE.
- Async reset mid-PLAY: assert rst between clk22 edges -> tone_out = REST_TONE, rec_len = 0 and state_out = 0 without a clock; a subsequent play_start is ignored.

Source files
------------

// File: rtl/beat_recorder.sv
// beat_recorder: beat-synchronous melody recorder / player, one beat per clk22.
//   RECORD samples note_in once per beat into a score RAM; PLAY reads it back
//   and emits the matching tone frequency in Hz.
// Ports:
//   clk22, rst          beat clock, async active-high reset
//   rec_start/play_start/stop  level inputs, rising edge is the command
//   note_in   [3:0]     0 rest, 1..8 C4..C5, 9..15 treated as rest
//   tone_out  [31:0]    registered tone in Hz (REST_TONE for silence)
//   state_out [1:0]     0 IDLE, 1 RECORD, 2 PLAY
//   beat_idx            current write/read pointer
//   rec_len             recorded beats, 0..DEPTH
//   full                last RECORD ended because the RAM filled
module beat_recorder #(
   parameter int          ADDR_W    = 10,
   parameter bit          LOOP      = 1'b1,
   parameter logic [31:0] REST_TONE = 32'd20000
) (
   input  logic              clk22,
   input  logic              rst,
   input  logic              rec_start,
   input  logic              play_start,
   input  logic              stop,
   input  logic [3:0]        note_in,
   output logic [31:0]       tone_out,
   output logic [1:0]        state_out,
   output logic [ADDR_W-1:0] beat_idx,
   output logic [ADDR_W:0]   rec_len,
   output logic              full
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REC  = 2'd1,
      S_PLAY = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic              rec_q, play_q, stop_q;
   logic              cmd_rec, cmd_play, cmd_stop;
   logic [3:0]        mem [DEPTH];
   logic [3:0]        rd_data;
   logic              rd_vld, rd_vld_nx;
   logic [ADDR_W-1:0] beat_nx;
   logic [ADDR_W:0]   len_nx;
   logic              full_nx, we;
   logic [31:0]       tone_nx;
   logic [3:0]        note_clean;

   function automatic logic [31:0] note_tone(input logic [3:0] n);
      case (n)
         4'd1:    note_tone = 32'd262;
         4'd2:    note_tone = 32'd294;
         4'd3:    note_tone = 32'd330;
         4'd4:    note_tone = 32'd349;
         4'd5:    note_tone = 32'd392;
         4'd6:    note_tone = 32'd440;
         4'd7:    note_tone = 32'd494;
         4'd8:    note_tone = 32'd523;
         default: note_tone = REST_TONE;
      endcase
   endfunction

   assign cmd_rec    = rec_start  & ~rec_q;
   assign cmd_play   = play_start & ~play_q;
   assign cmd_stop   = stop       & ~stop_q;
   assign note_clean = (note_in > 4'd8) ? 4'd0 : note_in;
   assign state_out  = state;

   always_comb begin
      state_nx  = state;
      beat_nx   = beat_idx;
      len_nx    = rec_len;
      full_nx   = full;
      rd_vld_nx = 1'b0;
      tone_nx   = REST_TONE;
      we        = 1'b0;
      case (state)
         S_IDLE: begin
            // drains the last read of a non-looping score for one beat
            if (rd_vld) tone_nx = note_tone(rd_data);
            if (cmd_stop) begin
               tone_nx = REST_TONE;
            end else if (cmd_rec) begin
               state_nx = S_REC;
               beat_nx  = '0;
               len_nx   = '0;
               full_nx  = 1'b0;
               tone_nx  = REST_TONE;
            end else if (cmd_play && rec_len != '0) begin
               state_nx = S_PLAY;
               beat_nx  = '0;
               tone_nx  = REST_TONE;
            end
         end
         S_REC: begin
            if (cmd_stop) begin
               state_nx = S_IDLE;
               beat_nx  = '0;
            end else if (cmd_rec) begin
               beat_nx = '0;
               len_nx  = '0;
               full_nx = 1'b0;
            end else begin
               we      = 1'b1;
               tone_nx = note_tone(note_clean);
               len_nx  = rec_len + 1'b1;
               if (&beat_idx) begin
                  full_nx  = 1'b1;
                  state_nx = S_IDLE;
                  beat_nx  = '0;
               end else begin
                  beat_nx = beat_idx + 1'b1;
               end
            end
         end
         S_PLAY: begin
            if (cmd_stop) begin
               state_nx = S_IDLE;
               beat_nx  = '0;
            end else if (cmd_rec) begin
               state_nx = S_REC;
               beat_nx  = '0;
               len_nx   = '0;
               full_nx  = 1'b0;
            end else if (cmd_play) begin
               beat_nx = '0;
            end else begin
               // a read is issued this edge; its data lands in rd_data
               rd_vld_nx = 1'b1;
               if (rd_vld) tone_nx = note_tone(rd_data);
               if ({1'b0, beat_idx} == rec_len - 1'b1) begin
                  beat_nx = '0;
                  if (!LOOP) state_nx = S_IDLE;
               end else begin
                  beat_nx = beat_idx + 1'b1;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk22 or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         rec_q    <= 1'b0;
         play_q   <= 1'b0;
         stop_q   <= 1'b0;
         rd_vld   <= 1'b0;
         beat_idx <= '0;
         rec_len  <= '0;
         full     <= 1'b0;
         tone_out <= REST_TONE;
      end else begin
         state    <= state_nx;
         rec_q    <= rec_start;
         play_q   <= play_start;
         stop_q   <= stop;
         rd_vld   <= rd_vld_nx;
         beat_idx <= beat_nx;
         rec_len  <= len_nx;
         full     <= full_nx;
         tone_out <= tone_nx;
      end
   end

   // score RAM: not reset; rec_len 0 hides stale contents
   always_ff @(posedge clk22) begin
      if (we && !rst) mem[beat_idx] <= note_clean;
      rd_data <= mem[beat_idx];
   end

endmodule

// File: tb/tb_beat_recorder.sv
// Directed bench for beat_recorder. Three instances share stimulus:
// u_main (defaults, LOOP=1), u_nl (LOOP=0), u_sm (ADDR_W=3).
module tb_beat_recorder;
   localparam logic [31:0] REST = 32'd20000;

   logic clk22 = 1'b0;
   logic rst = 1'b1;
   logic rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
   logic [3:0] note_in = 4'd0;

   logic [31:0] m_tone, n_tone, s_tone;
   logic [1:0]  m_state, n_state, s_state;
   logic [9:0]  m_beat, n_beat;
   logic [2:0]  s_beat;
   logic [10:0] m_len, n_len;
   logic [3:0]  s_len;
   logic        m_full, n_full, s_full;

   int pass_cnt = 0;
   int total = 0;

   always #5 clk22 = ~clk22;

   beat_recorder u_main (
      .clk22(clk22), .rst(rst), .rec_start(rec_start), .play_start(play_start),
      .stop(stop), .note_in(note_in), .tone_out(m_tone), .state_out(m_state),
      .beat_idx(m_beat), .rec_len(m_len), .full(m_full));

   beat_recorder #(.LOOP(1'b0)) u_nl (
      .clk22(clk22), .rst(rst), .rec_start(rec_start), .play_start(play_start),
      .stop(stop), .note_in(note_in), .tone_out(n_tone), .state_out(n_state),
      .beat_idx(n_beat), .rec_len(n_len), .full(n_full));

   beat_recorder #(.ADDR_W(3)) u_sm (
      .clk22(clk22), .rst(rst), .rec_start(rec_start), .play_start(play_start),
      .stop(stop), .note_in(note_in), .tone_out(s_tone), .state_out(s_state),
      .beat_idx(s_beat), .rec_len(s_len), .full(s_full));

   // one clk22 edge, then settle; inputs change and outputs are sampled here
   task automatic step();
      @(posedge clk22);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1; rec_start = 0; play_start = 0; stop = 0; note_in = 0;
      step(); step();
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (m_tone !== REST) $display("FAIL reset_tone got %0d want %0d", m_tone, REST); else pass_cnt++;
      total++; if (m_state !== 2'd0) $display("FAIL reset_state got %0d want 0", m_state); else pass_cnt++;
      total++; if (m_beat !== 10'd0 || m_len !== 11'd0 || m_full !== 1'b0)
         $display("FAIL reset_regs got beat=%0d len=%0d full=%0d want 0/0/0", m_beat, m_len, m_full);
      else pass_cnt++;
   endtask

   task automatic test_record();
      logic [3:0] notes [4] = '{4'd1, 4'd3, 4'd5, 4'd0};
      do_reset();
      rec_start = 1; step(); rec_start = 0;
      total++; if (m_state !== 2'd1) $display("FAIL rec_enter got %0d want 1", m_state); else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         note_in = notes[i]; step();
         if (i == 0) begin
            total++; if (m_tone !== 32'd262) $display("FAIL rec_monitor got %0d want 262", m_tone); else pass_cnt++;
         end
      end
      note_in = 0; stop = 1; step(); stop = 0;
      total++; if (m_len !== 11'd4 || m_state !== 2'd0 || m_full !== 1'b0)
         $display("FAIL rec_stop got len=%0d st=%0d full=%0d want 4/0/0", m_len, m_state, m_full);
      else pass_cnt++;
      total++; if (m_tone !== REST) $display("FAIL rec_stop_tone got %0d want %0d", m_tone, REST); else pass_cnt++;
   endtask

   // runs on the recording left by test_record
   task automatic test_play_loop();
      logic [31:0] exp_m [7] = '{REST, 32'd262, 32'd330, 32'd392, REST, 32'd262, 32'd330};
      play_start = 1; step(); play_start = 0;   // E0
      total++; if (m_state !== 2'd2) $display("FAIL play_enter got %0d want 2", m_state); else pass_cnt++;
      for (int e = 1; e <= 7; e++) begin
         step();
         total++; if (m_tone !== exp_m[e-1]) $display("FAIL play_loop_tone E%0d got %0d want %0d", e, m_tone, exp_m[e-1]); else pass_cnt++;
         if (e == 4) begin
            total++; if (m_beat !== 10'd0) $display("FAIL play_wrap got %0d want 0", m_beat); else pass_cnt++;
            total++; if (n_state !== 2'd0 || n_tone !== 32'd392)
               $display("FAIL noloop_end got st=%0d tone=%0d want 0/392", n_state, n_tone);
            else pass_cnt++;
         end
         if (e == 5 || e == 6) begin
            total++; if (n_tone !== REST || n_state !== 2'd0)
               $display("FAIL noloop_idle E%0d got tone=%0d st=%0d want %0d/0", e, n_tone, n_state, REST);
            else pass_cnt++;
         end
      end
      stop = 1; step(); stop = 0;
      total++; if (m_tone !== REST || m_state !== 2'd0)
         $display("FAIL play_stop got tone=%0d st=%0d want %0d/0", m_tone, m_state, REST);
      else pass_cnt++;
   endtask

   task automatic test_full();
      do_reset();
      rec_start = 1; step(); rec_start = 0;
      note_in = 4'd6;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (i == 8) begin
            total++; if (s_state !== 2'd0 || s_full !== 1'b1)
               $display("FAIL full_auto_idle got st=%0d full=%0d want 0/1", s_state, s_full);
            else pass_cnt++;
         end
      end
      note_in = 0;
      total++; if (s_len !== 4'd8 || s_full !== 1'b1 || s_state !== 2'd0)
         $display("FAIL full_end got len=%0d full=%0d st=%0d want 8/1/0", s_len, s_full, s_state);
      else pass_cnt++;
      total++; if (m_len !== 11'd10 || m_full !== 1'b0)
         $display("FAIL big_len got len=%0d full=%0d want 10/0", m_len, m_full);
      else pass_cnt++;
      play_start = 1; step(); play_start = 0;
      step();
      for (int e = 2; e <= 11; e++) begin
         step();
         total++; if (s_tone !== 32'd440) $display("FAIL full_play E%0d got %0d want 440", e, s_tone); else pass_cnt++;
      end
   endtask

   task automatic test_edge_cases();
      do_reset();
      play_start = 1; step(); step(); play_start = 0;
      total++; if (m_state !== 2'd0 || m_beat !== 10'd0)
         $display("FAIL play_empty got st=%0d beat=%0d want 0/0", m_state, m_beat);
      else pass_cnt++;
      step();
      stop = 1; rec_start = 1; play_start = 1; step();
      total++; if (m_state !== 2'd0) $display("FAIL all_cmd_idle got %0d want 0", m_state); else pass_cnt++;
      stop = 0; rec_start = 0; play_start = 0; step();
      rec_start = 1; step(); rec_start = 0; step();
      stop = 1; rec_start = 1; play_start = 1; step();
      total++; if (m_state !== 2'd0 || m_len !== 11'd1)
         $display("FAIL all_cmd_rec got st=%0d len=%0d want 0/1", m_state, m_len);
      else pass_cnt++;
      stop = 0; rec_start = 0; play_start = 0; step();
   endtask

   task automatic test_invalid_note_and_async_reset();
      do_reset();
      rec_start = 1; step(); rec_start = 0;
      note_in = 4'd12; step();
      note_in = 4'd2;  step();
      note_in = 0; stop = 1; step(); stop = 0;
      play_start = 1; step(); play_start = 0;
      step(); step();
      total++; if (m_tone !== REST) $display("FAIL note12_rest got %0d want %0d", m_tone, REST); else pass_cnt++;
      step();
      total++; if (m_tone !== 32'd294) $display("FAIL note2_play got %0d want 294", m_tone); else pass_cnt++;
      // async reset between edges
      rst = 1'b1; #1;
      total++; if (m_tone !== REST || m_len !== 11'd0 || m_state !== 2'd0)
         $display("FAIL async_rst got tone=%0d len=%0d st=%0d want %0d/0/0", m_tone, m_len, m_state, REST);
      else pass_cnt++;
      #1 rst = 1'b0;
      step();
      play_start = 1; step(); step(); play_start = 0;
      total++; if (m_state !== 2'd0 || m_tone !== REST)
         $display("FAIL post_rst_play got st=%0d tone=%0d want 0/%0d", m_state, m_tone, REST);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_record();
      test_play_loop();
      test_full();
      test_edge_cases();
      test_invalid_note_and_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end
endmodule
